// File: rtl/qdiv_pkg.sv
// qdiv_pkg: shared state encoding and sizing helpers for the qdiv_stream divider
package qdiv_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, FINISH, DONE} state_t;
  function automatic int iter_count(input int n, input int q, input int round);
    return n - 1 + q + round;
  endfunction
  function automatic int cnt_width(input int n, input int q, input int round);
    return $clog2(iter_count(n, q, round));
  endfunction
endpackage

// File: rtl/qdiv_round_sat.sv
// qdiv_round_sat: combinational rounding, saturation and sign cleanup of a raw quotient
//   raw      in  ITER  raw quotient bits (one extra half bit when ROUND=1)
//   sign     in  1     result sign
//   dbz      in  1     divisor was zero: saturate without flagging overflow
//   quotient out N     final sign-magnitude quotient
//   ovf      out 1     magnitude saturated because it did not fit
module qdiv_round_sat #(
  parameter int N = 32,
  parameter int Q = 15,
  parameter int ROUND = 0,
  parameter int ITER = N - 1 + Q + ROUND
) (
  input  logic [ITER-1:0] raw,
  input  logic            sign,
  input  logic            dbz,
  output logic [N-1:0]    quotient,
  output logic            ovf
);
  localparam int M = N - 1 + Q;
  logic [M-1:0] mag;
  logic [N-2:0] m;
  logic big;
  generate
    if (ROUND != 0) begin : g_rnd
      assign mag = raw[ITER-1:1] + M'(raw[0]);
    end else begin : g_trn
      assign mag = raw;
    end
  endgenerate
  assign big = |mag[M-1:N-1];
  assign ovf = big && !dbz;
  assign m = (big || dbz) ? '1 : mag[N-2:0];
  assign quotient = {sign && |m, m};
endmodule

// File: rtl/qdiv_stream.sv
// qdiv_stream: sequential sign-magnitude fixed-point divider with valid/ready handshakes
//   in_valid/in_ready     operand handshake, accepted only in IDLE
//   dividend/divisor      N-bit sign-magnitude Q-format operands
//   out_valid/out_ready   result handshake, held in DONE
//   quotient/ovf/dbz      registered result and status flags
//   busy                  high while dividing or finishing
module qdiv_stream import qdiv_pkg::*; #(
  parameter int N = 32,
  parameter int Q = 15,
  parameter int ROUND = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] quotient,
  output logic         ovf,
  output logic         dbz,
  output logic         busy
);
  localparam int ITER = iter_count(N, Q, ROUND);
  localparam int CW = cnt_width(N, Q, ROUND);
  localparam int NM = N - 1;
  state_t state, state_nx;
  logic [ITER-1:0] nq;
  logic [N-2:0] dvs, rem;
  logic [N-1:0] sh, q_fin;
  logic [CW-1:0] cnt;
  logic sgn, dz, take, ovf_fin;
  // nq shifts dividend bits out of the top while quotient bits enter at the bottom
  assign sh = {rem, nq[ITER-1]};
  assign take = sh >= {1'b0, dvs};
  assign in_ready = state == IDLE;
  assign out_valid = state == DONE;
  assign busy = state == BUSY || state == FINISH;
  always_comb begin
    state_nx = state == IDLE   ? (in_valid ? (divisor[N-2:0] == '0 ? FINISH : BUSY) : IDLE) :
               state == BUSY   ? (cnt == '0 ? FINISH : BUSY) :
               state == FINISH ? DONE :
               (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nq <= '0;
      dvs <= '0;
      rem <= '0;
      cnt <= '0;
      sgn <= 1'b0;
      dz <= 1'b0;
      quotient <= '0;
      ovf <= 1'b0;
      dbz <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      nq <= {dividend[N-2:0], {(Q + ROUND){1'b0}}};
      dvs <= divisor[N-2:0];
      rem <= '0;
      cnt <= CW'(ITER - 1);
      sgn <= dividend[N-1] ^ divisor[N-1];
      dz <= divisor[N-2:0] == '0;
      ovf <= 1'b0;
      dbz <= 1'b0;
    end else if (state == BUSY) begin
      rem <= take ? NM'(sh - {1'b0, dvs}) : sh[N-2:0];
      nq <= {nq[ITER-2:0], take};
      cnt <= cnt - 1'b1;
    end else if (state == FINISH) begin
      quotient <= q_fin;
      ovf <= ovf_fin;
      dbz <= dz;
    end
  end
  qdiv_round_sat #(.N(N), .Q(Q), .ROUND(ROUND), .ITER(ITER)) u_round_sat (
    .raw(nq),
    .sign(sgn),
    .dbz(dz),
    .quotient(q_fin),
    .ovf(ovf_fin)
  );
endmodule
